load_use_operand_hold: RTL and testbench
========================================

// Module: load_use_operand_hold
// PURPOSE
//  Per-channel operand hold buffer at the ID/EX boundary. When the hazard unit flags a load-use bubble on a
//  channel, the block captures that channel's EX operand and replays it for HOLD_CYCLES cycles, extended while
//  the pipeline is stalled. All other times the live operand passes straight through. Sits between the
//  register-read/forwarding muxes and the ALU operand inputs; supports N operand channels and multi-cycle stalls.
// PARAMETERS
//  NUM_CH       2   number of operand channels (>=1)
//  WIDTH        32  operand width in bits
//  HOLD_CYCLES  1   replay length in unstalled cycles (>=1)
//  CNT_W        $clog2(HOLD_CYCLES+1)  hold counter width (derived, not overridden)
// PORTS
//  clk          in   1             sole clock, rising edge
//  rst_n        in   1             asynchronous, active-low reset
//  ex_data      in   NUM_CH*WIDTH  live operands; channel c = [c*WIDTH +: WIDTH]
//  load_use     in   NUM_CH        per-channel load-use bubble flag, sampled each edge
//  stall        in   1             global pipeline freeze; holds counters, extends replay
//  flush        in   1             synchronous pipeline flush
//  ex_operand   out  NUM_CH*WIDTH  operands to ALU (held or live)
//  hold_active  out  NUM_CH        1 while channel c is replaying
//  lu_event_cnt out  16            load-use capture count (see CONFIGURATION)
// BEHAVIOUR
//  Reset (rst_n=0, async): all channels IDLE, captured data 0, counters 0; hold_active=0, lu_event_cnt=0;
//   ex_operand = ex_data (combinational passthrough).
//  Per-channel FSM, states IDLE, HOLD; priority at each edge: flush > load_use > count.
//  IDLE: load_use[c]=1 at edge -> capture ex_data[c], cnt=HOLD_CYCLES, go HOLD (stall irrelevant to capture).
//  HOLD: ex_operand[c]=captured, hold_active[c]=1.
//   stall=1 -> cnt and data frozen, stay HOLD.
//   stall=0, cnt>1 -> cnt-1. stall=0, cnt==1 -> IDLE.
//   load_use[c]=1 while HOLD -> cnt reloaded to HOLD_CYCLES, captured data NOT overwritten (older operand valid).
//  flush=1 at edge -> every channel IDLE, cnt=0, captured data kept; passthrough next cycle.
//  Latency: capture at edge ending cycle t; replay covers cycles t+1..t+HOLD_CYCLES plus stall cycles;
//   output mux is combinational from state and registers, no added latency in IDLE.
//  Channels independent; simultaneous load_use on several channels captured in parallel.
//  Reset mid-hold: immediate IDLE, passthrough without waiting for a clock edge.
// CONFIGURATION
//  LOAD_USE_EVENT_CNT_EN defined: lu_event_cnt increments by popcount of channels entering HOLD from IDLE at
//   each edge (flush edge excluded), saturating at 16'hFFFF; reset to 0.
//  Undefined: counter logic absent, lu_event_cnt tied to 16'h0; all other behaviour identical.
// STRUCTURE
//  Package lu_hold_pkg: state enum typedef (LU_IDLE, LU_HOLD), LU_EVENT_CNT_W=16 constant.
//  Sub-module lu_hold_channel: one FSM + capture register + counter (WIDTH, HOLD_CYCLES); top instantiates
//   NUM_CH copies via generate, plus the optional event counter.
// TESTING
//  1 Reset: rst_n=0 mid-cycle with ex_data=32'hDEAD_BEEF -> ex_operand=DEADBEEF same cycle, hold_active=0.
//  2 HOLD_CYCLES=1: ch0 load_use with ex_data=32'h1111, next cycle ex_data=32'h2222 -> out 1111 for 1 cycle, then 2222.
//  3 Stall extend: capture 32'hA5A5, stall=1 for 3 cycles -> A5A5 held 4 cycles total, hold_active=1 throughout.
//  4 Re-trigger: HOLD_CYCLES=2, load_use again in 2nd hold cycle, new data 32'h7 -> output stays first value, hold ends 2 cycles after retrigger.
//  5 Flush during HOLD with stall=1 -> next cycle passthrough, hold_active=0; both channels captured same edge -> independent release.
//  6 LOAD_USE_EVENT_CNT_EN: 3 dual-channel captures -> cnt=6; preset near 16'hFFFF -> saturates; macro off -> cnt=0.

Source files
------------

// File: rtl/lu_hold_pkg.sv
// Shared types for the load-use operand hold buffer.
// Channel FSM state encoding and event counter width.
package lu_hold_pkg;

  typedef enum logic {
    LU_IDLE = 1'b0,
    LU_HOLD = 1'b1
  } lu_state_e;

  localparam int LU_EVENT_CNT_W = 16;

endpackage

// File: rtl/lu_hold_channel.sv
// One operand channel: capture register, replay counter, IDLE/HOLD FSM.
// enter pulses on an edge-bound IDLE->HOLD transition (not on flush).
module lu_hold_channel
  import lu_hold_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int HOLD_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] ex_data,
  input  logic             load_use,
  input  logic             stall,
  input  logic             flush,
  output logic [WIDTH-1:0] ex_operand,
  output logic             hold_active,
  output logic             enter
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  lu_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    enter   = 1'b0;
    unique case (1'b1)
      flush: begin
        state_d = LU_IDLE;
        cnt_d   = '0;
      end
      load_use: begin
        cnt_d   = CNT_LOAD;
        state_d = LU_HOLD;
        // A re-trigger keeps the older operand; it is still the valid one.
        if (state_q == LU_IDLE) begin
          data_d = ex_data;
          enter  = 1'b1;
        end
      end
      default: begin
        if (state_q == LU_HOLD && !stall) begin
          if (cnt_q > CNT_ONE) begin
            cnt_d = cnt_q - CNT_ONE;
          end else begin
            cnt_d   = '0;
            state_d = LU_IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LU_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  assign hold_active = (state_q == LU_HOLD);
  assign ex_operand  = hold_active ? data_q : ex_data;

endmodule

// File: rtl/load_use_operand_hold.sv
// Per-channel load-use operand hold buffer at the ID/EX boundary.
// Optional capture counter enabled by LOAD_USE_EVENT_CNT_EN.
module load_use_operand_hold
  import lu_hold_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int WIDTH       = 32,
  parameter int HOLD_CYCLES = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_CH*WIDTH-1:0]   ex_data,
  input  logic [NUM_CH-1:0]         load_use,
  input  logic                      stall,
  input  logic                      flush,
  output logic [NUM_CH*WIDTH-1:0]   ex_operand,
  output logic [NUM_CH-1:0]         hold_active,
  output logic [LU_EVENT_CNT_W-1:0] lu_event_cnt
);

  logic [NUM_CH-1:0] enter;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    lu_hold_channel #(
      .WIDTH       (WIDTH),
      .HOLD_CYCLES (HOLD_CYCLES)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .ex_data     (ex_data[c*WIDTH +: WIDTH]),
      .load_use    (load_use[c]),
      .stall       (stall),
      .flush       (flush),
      .ex_operand  (ex_operand[c*WIDTH +: WIDTH]),
      .hold_active (hold_active[c]),
      .enter       (enter[c])
    );
  end

`ifdef LOAD_USE_EVENT_CNT_EN
  logic [LU_EVENT_CNT_W-1:0] ev_cnt_q, ev_cnt_d;
  logic [LU_EVENT_CNT_W:0]   ev_sum;

  // Saturating add of this edge's capture popcount.
  always_comb begin
    ev_sum = {1'b0, ev_cnt_q};
    for (int c = 0; c < NUM_CH; c++) begin
      ev_sum = ev_sum + {{LU_EVENT_CNT_W{1'b0}}, enter[c]};
    end
    ev_cnt_d = ev_sum[LU_EVENT_CNT_W] ? '1 : ev_sum[LU_EVENT_CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ev_cnt_q <= '0;
    end else begin
      ev_cnt_q <= ev_cnt_d;
    end
  end

  assign lu_event_cnt = ev_cnt_q;
`else
  logic unused_enter;
  assign unused_enter = ^enter;
  assign lu_event_cnt = '0;
`endif

endmodule

// File: tb/tb_load_use_operand_hold.sv
// Directed bench for load_use_operand_hold (default, HOLD_CYCLES=2, wide).
// Counter expectations follow LOAD_USE_EVENT_CNT_EN.
module tb_load_use_operand_hold;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // DUT A: defaults (2 ch, 32b, HOLD_CYCLES=1)
  logic [63:0] ex_data;
  logic [1:0]  load_use;
  logic        stall, flush;
  logic [63:0] ex_operand;
  logic [1:0]  hold_active;
  logic [15:0] lu_event_cnt;

  // DUT B: 1 ch, HOLD_CYCLES=2
  logic [31:0] ex_data2;
  logic        load_use2;
  logic [31:0] ex_operand2;
  logic        hold_active2;
  logic [15:0] lu_event_cnt2;

  // DUT C: 16 ch, 8b, saturation
  logic [127:0] ex_data3;
  logic [15:0]  load_use3;
  logic [127:0] ex_operand3;
  logic [15:0]  hold_active3;
  logic [15:0]  lu_event_cnt3;

  load_use_operand_hold u_dut (
    .clk(clk), .rst_n(rst_n), .ex_data(ex_data), .load_use(load_use),
    .stall(stall), .flush(flush), .ex_operand(ex_operand),
    .hold_active(hold_active), .lu_event_cnt(lu_event_cnt)
  );

  load_use_operand_hold #(.NUM_CH(1), .WIDTH(32), .HOLD_CYCLES(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .ex_data(ex_data2), .load_use(load_use2),
    .stall(1'b0), .flush(1'b0), .ex_operand(ex_operand2),
    .hold_active(hold_active2), .lu_event_cnt(lu_event_cnt2)
  );

  load_use_operand_hold #(.NUM_CH(16), .WIDTH(8), .HOLD_CYCLES(1)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .ex_data(ex_data3), .load_use(load_use3),
    .stall(1'b0), .flush(1'b0), .ex_operand(ex_operand3),
    .hold_active(hold_active3), .lu_event_cnt(lu_event_cnt3)
  );

`ifdef LOAD_USE_EVENT_CNT_EN
  localparam logic [15:0] EXP6   = 16'd6;
  localparam logic [15:0] EXP16  = 16'd16;
  localparam logic [15:0] EXPSAT = 16'hFFFF;
`else
  localparam logic [15:0] EXP6   = 16'd0;
  localparam logic [15:0] EXP16  = 16'd0;
  localparam logic [15:0] EXPSAT = 16'd0;
`endif

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and are checked between rising edges.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    load_use = '0; load_use2 = 1'b0; load_use3 = '0;
    ex_data = {32'hDEAD_BEEF, 32'hDEAD_BEEF};
    ex_data2 = 32'h0; ex_data3 = '0;
    #3;
    check("rst_pass", ex_operand, {32'hDEAD_BEEF, 32'hDEAD_BEEF});
    check("rst_hold", hold_active, 2'b00);
    check("rst_cnt", lu_event_cnt, 16'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // HOLD_CYCLES=1 replay
    load_use = 2'b01; ex_data = {32'h0, 32'h1111};
    #1 check("t2_c0", ex_operand[31:0], 32'h1111);
    tick();
    load_use = 2'b00; ex_data = {32'h0, 32'h2222};
    #1 check("t2_hold", ex_operand[31:0], 32'h1111);
    check("t2_act", hold_active, 2'b01);
    tick();
    check("t2_rel", ex_operand[31:0], 32'h2222);
    check("t2_idle", hold_active, 2'b00);

    // stall extends replay
    load_use = 2'b01; ex_data = {32'h0, 32'hA5A5};
    tick();
    load_use = 2'b00; stall = 1'b1; ex_data = {32'h0, 32'h0BAD};
    for (int i = 0; i < 3; i++) begin
      #1 check("t3_stall", {hold_active, ex_operand[31:0]}, {2'b01, 32'hA5A5});
      tick();
    end
    stall = 1'b0;
    #1 check("t3_last", {hold_active, ex_operand[31:0]}, {2'b01, 32'hA5A5});
    tick();
    check("t3_rel", {hold_active, ex_operand[31:0]}, {2'b00, 32'h0BAD});

    // re-trigger on DUT B (HOLD_CYCLES=2)
    load_use2 = 1'b1; ex_data2 = 32'h55;
    tick();
    load_use2 = 1'b0; ex_data2 = 32'h7;
    #1 check("t4_h1", {hold_active2, ex_operand2}, {1'b1, 32'h55});
    tick();
    load_use2 = 1'b1;
    #1 check("t4_h2", {hold_active2, ex_operand2}, {1'b1, 32'h55});
    tick();
    load_use2 = 1'b0;
    #1 check("t4_r1", {hold_active2, ex_operand2}, {1'b1, 32'h55});
    tick();
    check("t4_r2", {hold_active2, ex_operand2}, {1'b1, 32'h55});
    tick();
    check("t4_rel", {hold_active2, ex_operand2}, {1'b0, 32'h7});

    // flush during stalled hold, dual capture
    load_use = 2'b11; ex_data = {32'h200, 32'h100};
    tick();
    load_use = 2'b00; stall = 1'b1; flush = 1'b1;
    ex_data = {32'h400, 32'h300};
    #1 check("t5_held", {hold_active, ex_operand}, {2'b11, 32'h200, 32'h100});
    tick();
    stall = 1'b0; flush = 1'b0;
    #1 check("t5_flush", {hold_active, ex_operand}, {2'b00, 32'h400, 32'h300});

    // independent release after a shared capture
    load_use = 2'b11; ex_data = {32'h600, 32'h500};
    tick();
    load_use = 2'b10; ex_data = {32'h800, 32'h700};
    #1 check("t5_both", {hold_active, ex_operand}, {2'b11, 32'h600, 32'h500});
    tick();
    load_use = 2'b00;
    #1 check("t5_split", {hold_active, ex_operand}, {2'b10, 32'h600, 32'h700});
    tick();
    check("t5_done", {hold_active, ex_operand}, {2'b00, 32'h800, 32'h700});
    check("t5_evcnt", lu_event_cnt, EXP6);

    // async reset mid-hold
    load_use = 2'b01; ex_data = {32'h0, 32'h999};
    tick();
    load_use = 2'b00; ex_data = {32'h0, 32'hCAFE};
    #1 check("t1_pre", hold_active, 2'b01);
    rst_n = 1'b0;
    #1 check("t1_mid", {hold_active, ex_operand[31:0]}, {2'b00, 32'hCAFE});
    check("t1_cnt", lu_event_cnt, 16'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // three dual-channel captures
    for (int i = 0; i < 3; i++) begin
      load_use = 2'b11;
      tick();
      load_use = 2'b00;
      tick();
    end
    check("t6_six", lu_event_cnt, EXP6);

    load_use3 = 16'hFFFF;
    tick();
    load_use3 = 16'h0;
    tick();
    check("t6_wide", lu_event_cnt3, EXP16);
`ifdef LOAD_USE_EVENT_CNT_EN
    for (int i = 0; i < 4094; i++) begin
      load_use3 = 16'hFFFF;
      tick();
      load_use3 = 16'h0;
      tick();
    end
    check("t6_near", lu_event_cnt3, 16'hFFF0);
    for (int i = 0; i < 2; i++) begin
      load_use3 = 16'hFFFF;
      tick();
      load_use3 = 16'h0;
      tick();
    end
`endif
    check("t6_sat", lu_event_cnt3, EXPSAT);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
